// File: rtl/shacc_pkg.sv
// Shared constants for the multi-lane shifter-accumulator: default widths and
// the output-buffer state encoding.
package shacc_pkg;
    localparam int W_DEF  = 32;
    localparam int A_DEF  = 8;
    localparam int N_DEF  = 4;
    localparam int CW_DEF = 8;

    localparam logic BUF_EMPTY = 1'b0;
    localparam logic BUF_FULL  = 1'b1;
endpackage

// File: rtl/shacc_lane.sv
// One accumulator lane: sign-extend, optional negate, shift-add at W+2 bits,
// wrap to W bits and keep a sticky signed-overflow flag for the current job.
module shacc_lane
    import shacc_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         first,
    input  logic         shift,
    input  logic         neg,
    input  logic [A-1:0] data,
    output logic [W-1:0] nxt_acc,
    output logic         nxt_ovf
);

    logic [W-1:0] acc;
    logic         ovf;
    logic [W+1:0] x_ext;
    logic [W+1:0] x_sel;
    logic [W+1:0] base;
    logic [W+1:0] sum;
    logic         ovf_now;

    // Two guard bits make 2*acc + X and the negation of -2^(A-1) exact.
    assign x_ext = {{(W+2-A){data[A-1]}}, data};
    assign x_sel = neg ? -x_ext : x_ext;

    always_comb begin
        base = '0;
        if (!first) begin
            if (shift) base = {acc[W-1], acc, 1'b0};
            else       base = {{2{acc[W-1]}}, acc};
        end
    end

    assign sum     = base + x_sel;
    assign ovf_now = (sum[W+1:W-1] != 3'b000) && (sum[W+1:W-1] != 3'b111);
    assign nxt_acc = sum[W-1:0];
    assign nxt_ovf = ovf_now | (ovf & ~first);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= nxt_acc;
            ovf <= nxt_ovf;
        end
    end

endmodule

// File: rtl/shacc_lanes.sv
// Job sequencer for N shifter-accumulator lanes: plane/beat counters, shadow
// configuration, input handshake and a one-entry result buffer.
module shacc_lanes
    import shacc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int A  = A_DEF,
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [CW-1:0]  cfg_planes,
    input  logic [CW-1:0]  cfg_depth,
    input  logic           cfg_msb_neg,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*A-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_ovf,
    output logic           buf_state
);

    logic [CW-1:0]  p_cnt;
    logic [CW-1:0]  d_cnt;
    logic [CW-1:0]  sh_planes;
    logic [CW-1:0]  sh_depth;
    logic           sh_neg;
    logic [CW-1:0]  norm_planes;
    logic [CW-1:0]  norm_depth;
    logic [CW-1:0]  eff_planes;
    logic [CW-1:0]  eff_depth;
    logic           eff_neg;
    logic           first_beat;
    logic           last_d;
    logic           final_beat;
    logic           neg_beat;
    logic           shift_beat;
    logic           accept;
    logic [N*W-1:0] lane_acc;
    logic [N-1:0]   lane_ovf;

    // The first beat of a job uses the live cfg inputs; later beats use the
    // copy captured on that first beat.
    assign first_beat  = (p_cnt == '0) && (d_cnt == '0);
    assign norm_planes = (cfg_planes == '0) ? CW'(1) : cfg_planes;
    assign norm_depth  = (cfg_depth == '0) ? CW'(1) : cfg_depth;
    assign eff_planes  = first_beat ? norm_planes : sh_planes;
    assign eff_depth   = first_beat ? norm_depth : sh_depth;
    assign eff_neg     = first_beat ? cfg_msb_neg : sh_neg;

    assign last_d     = (d_cnt == eff_depth - CW'(1));
    assign final_beat = last_d && (p_cnt == eff_planes - CW'(1));
    assign neg_beat   = eff_neg && (p_cnt == '0);
    assign shift_beat = (d_cnt == '0) && (p_cnt != '0);

    // Handshake: a beat transfers on in_valid & in_ready, a result on
    // out_valid & out_ready. Only a final beat needs buffer space, and it may
    // use the slot being drained in the same cycle.
    assign in_ready  = !(final_beat && (buf_state == BUF_FULL) && !out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (buf_state == BUF_FULL);

    for (genvar i = 0; i < N; i++) begin : g_lane
        shacc_lane #(.W(W), .A(A)) u_lane (
            .clk     (clk),
            .clr_n   (clr_n),
            .en      (accept),
            .first   (first_beat),
            .shift   (shift_beat),
            .neg     (neg_beat),
            .data    (in_data[i*A +: A]),
            .nxt_acc (lane_acc[i*W +: W]),
            .nxt_ovf (lane_ovf[i])
        );
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            p_cnt     <= '0;
            d_cnt     <= '0;
            sh_planes <= CW'(1);
            sh_depth  <= CW'(1);
            sh_neg    <= 1'b0;
        end else if (accept) begin
            if (first_beat) begin
                sh_planes <= norm_planes;
                sh_depth  <= norm_depth;
                sh_neg    <= cfg_msb_neg;
            end
            if (final_beat) begin
                p_cnt <= '0;
                d_cnt <= '0;
            end else if (last_d) begin
                d_cnt <= '0;
                p_cnt <= p_cnt + CW'(1);
            end else begin
                d_cnt <= d_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            buf_state <= BUF_EMPTY;
            out_data  <= '0;
            out_ovf   <= '0;
        end else if (accept && final_beat) begin
            buf_state <= BUF_FULL;
            out_data  <= lane_acc;
            out_ovf   <= lane_ovf;
        end else if (out_valid && out_ready) begin
            buf_state <= BUF_EMPTY;
        end
    end

endmodule

// File: tb/tb_shacc_lanes.sv
// Self-checking bench for shacc_lanes: directed jobs, an 8-bit overflow
// instance, mid-job reset and a few randomised jobs against a reference model.
module tb_shacc_lanes;
    import shacc_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [7:0]  cfg_planes;
    logic [7:0]  cfg_depth;
    logic        cfg_msb_neg;
    logic        in_valid;
    logic        use8;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_valid32, in_ready32, out_valid32, buf_state32;
    logic [63:0] out_data32;
    logic [1:0]  out_ovf32;
    logic        in_valid8, in_ready8, out_valid8, buf_state8;
    logic [15:0] out_data8;
    logic [1:0]  out_ovf8;
    logic        in_ready_sel;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [65:0] exp_q32[$];
    logic [65:0] exp_q8[$];
    int          pop_cyc[$];
    logic [65:0] e32, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_valid32   = in_valid & ~use8;
    assign in_valid8    = in_valid & use8;
    assign in_ready_sel = use8 ? in_ready8 : in_ready32;

    shacc_lanes #(.W(32), .A(8), .N(2), .CW(8)) dut (
        .clk(clk), .clr_n(clr_n), .cfg_planes(cfg_planes), .cfg_depth(cfg_depth),
        .cfg_msb_neg(cfg_msb_neg), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_data(in_data), .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_ovf(out_ovf32), .buf_state(buf_state32)
    );

    shacc_lanes #(.W(8), .A(8), .N(2), .CW(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .cfg_planes(cfg_planes), .cfg_depth(cfg_depth),
        .cfg_msb_neg(cfg_msb_neg), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_ovf(out_ovf8), .buf_state(buf_state8)
    );

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] pk32(input int l0, input int l1, input logic [1:0] ovf);
        return {ovf, 32'(l1), 32'(l0)};
    endfunction

    function automatic logic [65:0] pk8(input int l0, input int l1, input logic [1:0] ovf);
        return {48'd0, ovf, 8'(l1), 8'(l0)};
    endfunction

    // Reference lane: exact integer arithmetic, wrap to 32 bits after each beat.
    function automatic logic [32:0] lane_model(input int np, input int nd, input bit neg,
                                               input int beats[$]);
        longint acc = 0;
        longint full = 0;
        longint x;
        bit ovf = 1'b0;
        int k = 0;
        logic signed [31:0] t = '0;
        for (int p = 0; p < np; p++) begin
            for (int d = 0; d < nd; d++) begin
                x = beats[k];
                k++;
                if (neg && p == 0) x = -x;
                if (p == 0 && d == 0) begin
                    full = x;
                    ovf  = 1'b0;
                end else if (d == 0) begin
                    full = 2 * acc + x;
                end else begin
                    full = acc + x;
                end
                if (full > 64'sd2147483647 || full < -64'sd2147483648) ovf = 1'b1;
                t   = full[31:0];
                acc = t;
            end
        end
        return {ovf, t};
    endfunction

    always @(negedge clk) begin
        if (clr_n && out_valid32 && out_ready) begin
            check("out32_expected", 66'(exp_q32.size() != 0), 66'(1));
            if (exp_q32.size() != 0) begin
                e32 = exp_q32.pop_front();
                check("out32", {out_ovf32, out_data32}, e32);
            end
            pop_cyc.push_back(cyc);
        end
        if (clr_n && out_valid8 && out_ready) begin
            check("out8_expected", 66'(exp_q8.size() != 0), 66'(1));
            if (exp_q8.size() != 0) begin
                e8 = exp_q8.pop_front();
                check("out8", {48'd0, out_ovf8, out_data8}, e8);
            end
        end
    end

    task automatic send_beat(input int l0, input int l1);
        int n = 0;
        in_data  = {8'(l1), 8'(l0)};
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_sel && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept", 66'(in_ready_sel), 66'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int d, input bit neg);
        cfg_planes  = 8'(p);
        cfg_depth   = 8'(d);
        cfg_msb_neg = neg;
    endtask

    task automatic wait_drain();
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q32.size() != 0 || exp_q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 66'(exp_q32.size() + exp_q8.size()), 66'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int np, nd;
        bit ng;
        int q0[$], q1[$];
        logic [32:0] r0, r1;

        clr_n = 1'b0; in_valid = 1'b0; use8 = 1'b0; out_ready = 1'b1;
        in_data = '0;
        set_cfg(1, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", 66'(out_valid32), 66'(0));
        check("rst_out", {out_ovf32, out_data32}, 66'(0));
        check("rst_in_ready", 66'(in_ready32), 66'(1));
        check("rst_buf_state", 66'(buf_state32), 66'(BUF_EMPTY));
        check("rst_out_valid8", 66'(out_valid8), 66'(0));
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Basic accumulate, one plane of three beats.
        set_cfg(1, 3, 1'b0);
        exp_q32.push_back(pk32(6, 0, 2'b00));
        send_beat(1, 0);
        send_beat(-4, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_not_early", 66'(out_valid32), 66'(0));
        @(posedge clk); #1;
        send_beat(9, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_latency", 66'(out_valid32), 66'(1));
        wait_drain();

        // Three single-beat planes, without and with MSB-plane negation.
        set_cfg(3, 1, 1'b0);
        exp_q32.push_back(pk32(5, 6, 2'b00));
        send_beat(1, 1); send_beat(0, 1); send_beat(1, 0);
        wait_drain();
        set_cfg(3, 1, 1'b1);
        exp_q32.push_back(pk32(-3, -2, 2'b00));
        send_beat(1, 1); send_beat(0, 1); send_beat(1, 0);
        wait_drain();

        // Held result while the next job streams in up to its final beat.
        out_ready = 1'b0;
        set_cfg(1, 3, 1'b0);
        exp_q32.push_back(pk32(6, 0, 2'b00));
        exp_q32.push_back(pk32(7, 0, 2'b00));
        send_beat(1, 0); send_beat(-4, 0); send_beat(9, 0);
        set_cfg(1, 2, 1'b0);
        in_data = {8'd0, 8'd3};
        @(negedge clk);
        check("t3_nonfinal_ready", 66'(in_ready32), 66'(1));
        check("t3_held_valid", 66'(out_valid32), 66'(1));
        @(posedge clk); #1;
        in_data = {8'd0, 8'd4};
        @(negedge clk);
        check("t3_final_stall", 66'(in_ready32), 66'(0));
        check("t3_held_data", {out_ovf32, out_data32}, pk32(6, 0, 2'b00));
        @(negedge clk);
        check("t3_final_stall2", 66'(in_ready32), 66'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_on_drain", 66'(in_ready32), 66'(1));
        @(posedge clk); #1;
        wait_drain();

        // Narrow instance: wrap and overflow, then a clean job clears the flag.
        use8 = 1'b1;
        set_cfg(1, 2, 1'b0);
        exp_q8.push_back(pk8(-56, 0, 2'b11));
        send_beat(100, -128); send_beat(100, -128);
        set_cfg(1, 1, 1'b0);
        exp_q8.push_back(pk8(5, -3, 2'b00));
        send_beat(5, -3);
        wait_drain();
        use8 = 1'b0;

        // Full-rate single-beat jobs.
        set_cfg(1, 1, 1'b0);
        base = pop_cyc.size();
        exp_q32.push_back(pk32(7, 0, 2'b00));
        exp_q32.push_back(pk32(-2, 1, 2'b00));
        exp_q32.push_back(pk32(3, -1, 2'b00));
        send_beat(7, 0); send_beat(-2, 1); send_beat(3, -1);
        wait_drain();
        check("t5_back_to_back",
              66'((pop_cyc.size() >= base + 3) ? pop_cyc[base+2] - pop_cyc[base] : -1),
              66'(2));

        // Reset mid-job with a result waiting; both are discarded.
        out_ready = 1'b0;
        set_cfg(1, 1, 1'b0);
        send_beat(2, 2);
        set_cfg(1, 3, 1'b0);
        send_beat(1, 1); send_beat(1, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_full_before_clr", 66'(out_valid32), 66'(1));
        #1 clr_n = 1'b0;
        #1;
        check("t6_clr_valid", 66'(out_valid32), 66'(0));
        check("t6_clr_data", {out_ovf32, out_data32}, 66'(0));
        @(posedge clk); #1;
        clr_n = 1'b1;
        out_ready = 1'b1;
        exp_q32.push_back(pk32(3, 3, 2'b00));
        send_beat(1, 1); send_beat(1, 1); send_beat(1, 1);
        wait_drain();

        // Random jobs; cfg is scrambled after the first beat of each.
        for (int j = 0; j < 10; j++) begin
            np = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            ng = 1'($urandom_range(0, 1));
            set_cfg(np, nd, ng);
            if (np == 0) np = 1;
            if (nd == 0) nd = 1;
            q0.delete(); q1.delete();
            for (int k = 0; k < np * nd; k++) begin
                q0.push_back(int'($urandom_range(0, 255)) - 128);
                q1.push_back(int'($urandom_range(0, 255)) - 128);
            end
            r0 = lane_model(np, nd, ng, q0);
            r1 = lane_model(np, nd, ng, q1);
            exp_q32.push_back({r1[32], r0[32], r1[31:0], r0[31:0]});
            for (int k = 0; k < np * nd; k++) begin
                send_beat(q0[k], q1[k]);
                if (k == 0) set_cfg($urandom_range(0, 7), $urandom_range(0, 7),
                                    1'($urandom_range(0, 1)));
            end
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
